// File: rtl/nios_system_onchip_ram_dp_pkg.sv
// Shared definitions for the dual-port on-chip RAM: latency bounds,
// width helpers and the per-port access classification.
package nios_onchip_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_e;

    function automatic int clog2(input int unsigned value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int BE_WIDTH(input int dw);
        return dw / 8;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

    // A write strobe wins over a simultaneous read strobe on the same port.
    function automatic acc_e access_kind(input logic cs, input logic rd,
                                         input logic wr, input logic en);
        acc_e kind;
        if (cs && en && wr) begin
            kind = ACC_WRITE;
        end else if (cs && en && rd) begin
            kind = ACC_READ;
        end else begin
            kind = ACC_IDLE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/nios_system_onchip_ram_dp_if.sv
// Avalon-MM slave port bundle used for each of the two RAM ports.
interface nios_system_onchip_ram_dp_if
    import nios_onchip_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int BW = BE_WIDTH(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [BW-1:0]         byteenable;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/nios_system_onchip_ram_dp_rd_pipe.sv
// Per-port read return pipeline: one or two registered stages that freeze
// while the clock enable is low, so a pending valid is stretched, not lost.
module nios_onchip_rd_pipe
    import nios_onchip_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] rd_word,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid
);

    generate
        if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
            $error("nios_onchip_rd_pipe: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic                  vld1_r;
    logic [DATA_WIDTH-1:0] dat1_r;

    // First stage captures the addressed word on an accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_r <= 1'b0;
            dat1_r <= '0;
        end else if (en) begin
            vld1_r <= rd;
            if (rd) begin
                dat1_r <= rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  vld2_r;
            logic [DATA_WIDTH-1:0] dat2_r;

            // Optional second output stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld2_r <= 1'b0;
                    dat2_r <= '0;
                end else if (en) begin
                    vld2_r <= vld1_r;
                    if (vld1_r) begin
                        dat2_r <= dat1_r;
                    end
                end
            end

            assign readdata      = dat2_r;
            assign readdatavalid = vld2_r;
        end else begin : g_lat1
            assign readdata      = dat1_r;
            assign readdatavalid = vld1_r;
        end
    endgenerate

endmodule

// File: rtl/nios_system_onchip_ram_dp.sv
// True dual-port on-chip RAM with byte enables, per-port read pipelines
// and a sticky same-address collision flag.
module nios_system_onchip_ram_dp
    import nios_onchip_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    DEPTH        = 1024,
    parameter int    ADDR_WIDTH   = clog2(DEPTH),
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "nios_system_onchip_memory_0.hex"
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         reset_req,
    input  logic                         clken,
    nios_system_onchip_ram_dp_if.slave   s1,
    nios_system_onchip_ram_dp_if.slave   s2,
    output logic                         collision
);

    localparam int BW = BE_WIDTH(DATA_WIDTH);

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_dw
            $error("nios_system_onchip_ram_dp: DATA_WIDTH must be a multiple of 8 in 8..128");
        end
        if (!is_pow2(DEPTH) || DEPTH < 16 || DEPTH > 65536) begin : g_bad_depth
            $error("nios_system_onchip_ram_dp: DEPTH must be a power of two in 16..65536");
        end
        if (ADDR_WIDTH != clog2(DEPTH)) begin : g_bad_aw
            $error("nios_system_onchip_ram_dp: ADDR_WIDTH must equal clog2(DEPTH)");
        end
        if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
            $error("nios_system_onchip_ram_dp: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic                  en_s;
    acc_e                  kind1_s;
    acc_e                  kind2_s;
    logic                  wr1_s;
    logic                  wr2_s;
    logic                  rd1_s;
    logic                  rd2_s;
    logic                  same_addr_s;
    logic                  hit_s;
    logic [BW-1:0]         be2_eff_s;
    logic [DATA_WIDTH-1:0] rd_word1_s;
    logic [DATA_WIDTH-1:0] rd_word2_s;
    logic [DATA_WIDTH-1:0] readdata1_s;
    logic [DATA_WIDTH-1:0] readdata2_s;
    logic                  readdatavalid1_s;
    logic                  readdatavalid2_s;
    logic                  collision_r;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    assign en_s    = clken & ~reset_req;
    assign kind1_s = access_kind(s1.chipselect, s1.read, s1.write, en_s);
    assign kind2_s = access_kind(s2.chipselect, s2.read, s2.write, en_s);
    assign wr1_s   = (kind1_s == ACC_WRITE);
    assign wr2_s   = (kind2_s == ACC_WRITE);
    assign rd1_s   = (kind1_s == ACC_READ);
    assign rd2_s   = (kind2_s == ACC_READ);

    assign same_addr_s = (s1.address == s2.address);
    assign hit_s       = same_addr_s && ((wr1_s && (wr2_s || rd2_s)) || (wr2_s && rd1_s));

    // s1 owns any byte both ports write at the same address; s2 keeps the rest.
    assign be2_eff_s = (same_addr_s && wr1_s) ? (s2.byteenable & ~s1.byteenable)
                                              : s2.byteenable;

    // Reads see the word as it stood before this edge's writes.
    assign rd_word1_s = mem_r[s1.address];
    assign rd_word2_s = mem_r[s2.address];

    // Byte-lane write merge for both ports; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BW; b++) begin
            if (wr1_s && s1.byteenable[b]) begin
                mem_r[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
            end
            if (wr2_s && be2_eff_s[b]) begin
                mem_r[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
            end
        end
    end

    // Sticky collision flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision_r <= 1'b0;
        end else if (hit_s) begin
            collision_r <= 1'b1;
        end
    end

    assign collision = collision_r;

    nios_onchip_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_s1 (
        .clk           (clk),
        .rst           (reset),
        .en            (en_s),
        .rd            (rd1_s),
        .rd_word       (rd_word1_s),
        .readdata      (readdata1_s),
        .readdatavalid (readdatavalid1_s)
    );

    nios_onchip_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_s2 (
        .clk           (clk),
        .rst           (reset),
        .en            (en_s),
        .rd            (rd2_s),
        .rd_word       (rd_word2_s),
        .readdata      (readdata2_s),
        .readdatavalid (readdatavalid2_s)
    );

    assign s1.readdata      = readdata1_s;
    assign s1.readdatavalid = readdatavalid1_s;
    assign s2.readdata      = readdata2_s;
    assign s2.readdatavalid = readdatavalid2_s;

endmodule

// File: tb/tb_nios_system_onchip_ram_dp.sv
// Bench for the dual-port RAM: a latency-1 and a latency-2 instance share
// clock and reset; read results are matched against a per-port scoreboard.
module tb_nios_system_onchip_ram_dp;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_req = 1'b0;
    logic clken = 1'b1;
    logic col1;
    logic col2;

    nios_system_onchip_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) a1();
    nios_system_onchip_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) a2();
    nios_system_onchip_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b1();
    nios_system_onchip_ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b2();

    nios_system_onchip_ram_dp #(
        .DATA_WIDTH(32), .DEPTH(1024), .ADDR_WIDTH(10), .READ_LATENCY(1), .INIT_FILE("")
    ) dut1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1(a1), .s2(a2), .collision(col1)
    );

    nios_system_onchip_ram_dp #(
        .DATA_WIDTH(32), .DEPTH(1024), .ADDR_WIDTH(10), .READ_LATENCY(2), .INIT_FILE("")
    ) dut2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1(b1), .s2(b2), .collision(col2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    ent_t q2[$];
    ent_t q3[$];

    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;
    logic edge_en = 1'b0;

    // Count the edges at which the RAM actually advances.
    always @(posedge clk) begin
        edge_en <= clken && !reset_req && !reset;
        if (clken && !reset_req && !reset) ecnt <= ecnt + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic cs, input logic rd, input logic wr,
                         input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        case (p)
            0: begin a1.chipselect = cs; a1.read = rd; a1.write = wr; a1.address = a; a1.byteenable = be; a1.writedata = d; end
            1: begin a2.chipselect = cs; a2.read = rd; a2.write = wr; a2.address = a; a2.byteenable = be; a2.writedata = d; end
            2: begin b1.chipselect = cs; b1.read = rd; b1.write = wr; b1.address = a; b1.byteenable = be; b1.writedata = d; end
            default: begin b2.chipselect = cs; b2.read = rd; b2.write = wr; b2.address = a; b2.byteenable = be; b2.writedata = d; end
        endcase
    endtask

    task automatic wr(input int p, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        drive(p, 1'b1, 1'b0, 1'b1, a, be, d);
    endtask

    // Present a read and record the data and en-cycle at which it must return.
    task automatic rd(input int p, input logic [9:0] a, input logic [31:0] exp);
        ent_t e;
        drive(p, 1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
        e.data = exp;
        e.due  = ecnt + ((p < 2) ? 1 : 2);
        case (p)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) drive(p, 1'b0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    endtask

    task automatic pop_chk(input int p, input logic v, input logic [31:0] d);
        ent_t e;
        bit   got;
        got    = 1'b0;
        e.data = 32'h0;
        e.due  = 0;
        if (v === 1'b0) return;
        case (p)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); got = 1'b1; end
        endcase
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL unexpected_valid port%0d observed valid=%b expected valid=0", p, v);
        end
        if (got) begin
            chk_eq($sformatf("rd_data_p%0d", p), d, e.data);
            chk_eq($sformatf("rd_cycle_p%0d", p), 32'(ecnt), 32'(e.due));
        end
    endtask

    // A new output can only appear after an edge at which the RAM advanced.
    always @(negedge clk) begin
        if (edge_en) begin
            pop_chk(0, a1.readdatavalid, a1.readdata);
            pop_chk(1, a2.readdatavalid, a2.readdata);
            pop_chk(2, b1.readdatavalid, b1.readdata);
            pop_chk(3, b2.readdatavalid, b2.readdata);
        end
    end

    initial begin
        for (int p = 0; p < 4; p++) drive(p, 1'b0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_a1_valid", 32'(a1.readdatavalid), 32'h0);
        chk_eq("rst_a1_data",  a1.readdata, 32'h0);
        chk_eq("rst_a2_valid", 32'(a2.readdatavalid), 32'h0);
        chk_eq("rst_b1_valid", 32'(b1.readdatavalid), 32'h0);
        chk_eq("rst_b2_data",  b2.readdata, 32'h0);
        chk_eq("rst_col1",     32'(col1), 32'h0);
        chk_eq("rst_col2",     32'(col2), 32'h0);
        reset = 1'b0;
        step();

        // Basic write on s1, read back on s2 at latency 1.
        wr(0, 10'd5, 4'hF, 32'hDEADBEEF);
        step();
        rd(1, 10'd5, 32'hDEADBEEF);
        step();
        step();
        chk_eq("lat1_pulse_done", 32'(a2.readdatavalid), 32'h0);

        // Byte enables, with a concurrent different-address read.
        wr(0, 10'd7, 4'hF, 32'h11223344);
        step();
        wr(0, 10'd7, 4'h5, 32'hAABBCCDD);
        rd(1, 10'd5, 32'hDEADBEEF);
        step();
        rd(0, 10'd7, 32'h11BB33DD);
        step();
        step();
        chk_eq("no_col_diff_addr", 32'(col1), 32'h0);

        // reset_req blocks writes and reads.
        reset_req = 1'b1;
        wr(0, 10'd5, 4'hF, 32'h00000000);
        drive(1, 1'b1, 1'b1, 1'b0, 10'd7, 4'h0, 32'h0);
        step();
        reset_req = 1'b0;
        rd(1, 10'd5, 32'hDEADBEEF);
        step();
        step();

        // Write/write collision.
        wr(0, 10'd3, 4'hF, 32'h00000000);
        wr(1, 10'd4, 4'hF, 32'h12345678);
        step();
        chk_eq("ww_diff_addr_no_col", 32'(col1), 32'h0);
        wr(0, 10'd3, 4'h3, 32'h000000FF);
        wr(1, 10'd3, 4'h6, 32'h0000EE00);
        step();
        chk_eq("ww_collision", 32'(col1), 32'h1);
        wr(0, 10'd4, 4'h1, 32'h000000AA);
        wr(1, 10'd4, 4'h2, 32'h0000BB00);
        step();
        rd(0, 10'd3, 32'h000000FF);
        rd(1, 10'd4, 32'h1234BBAA);
        step();
        step();

        // Latency 2: back-to-back reads with a clken stall mid-stream.
        for (int i = 0; i < 4; i++) begin
            wr(2, 10'(i), 4'hF, 32'hC0DE0000 + 32'(i));
            step();
        end
        chk_eq("lat2_no_col", 32'(col2), 32'h0);
        rd(2, 10'd0, 32'hC0DE0000);
        step();
        rd(2, 10'd1, 32'hC0DE0001);
        step();
        clken = 1'b0;
        drive(2, 1'b1, 1'b1, 1'b0, 10'd2, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(2, 1'b1, 1'b1, 1'b0, 10'd2, 4'h0, 32'h0);
            chk_eq("stall_valid_held", 32'(b1.readdatavalid), 32'h1);
            chk_eq("stall_data_held", b1.readdata, 32'hC0DE0000);
        end
        clken = 1'b1;
        rd(2, 10'd2, 32'hC0DE0002);
        step();
        rd(2, 10'd3, 32'hC0DE0003);
        step();
        step();
        step();
        chk_eq("stall_drained", 32'(q2.size()), 32'h0);

        // Same-address read/write across ports returns the old word.
        wr(3, 10'd9, 4'hF, 32'h00000001);
        step();
        chk_eq("rw_pre_no_col", 32'(col2), 32'h0);
        rd(3, 10'd9, 32'h00000001);
        wr(2, 10'd9, 4'hF, 32'h00000002);
        step();
        chk_eq("rw_collision", 32'(col2), 32'h1);
        rd(3, 10'd9, 32'h00000002);
        step();
        step();
        step();

        // Reset with a latency-2 read in flight.
        rd(2, 10'd1, 32'hC0DE0001);
        step();
        reset = 1'b1;
        #1;
        chk_eq("rst_mid_valid", 32'(b1.readdatavalid), 32'h0);
        chk_eq("rst_mid_data",  b1.readdata, 32'h0);
        chk_eq("rst_mid_col2",  32'(col2), 32'h0);
        chk_eq("rst_mid_col1",  32'(col1), 32'h0);
        q2.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) step();
        rd(2, 10'd1, 32'hC0DE0001);
        rd(3, 10'd9, 32'h00000002);
        step();
        step();
        step();

        chk_eq("queues_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
